// File: rtl/stopwatch_cmd_ctrl.sv
// stopwatch_cmd_ctrl
//   Command/control unit for the stopwatch time-counter datapath. Takes commands
//   from debounced buttons and UART RX bytes, arbitrates them to at most one command
//   per cycle, and runs a STOP/RUN/CLEAR state machine. The machine drives the
//   datapath's run level and clear level.
//
//   Optional feature, enabled by defining STOPWATCH_LAP_EN:
//     The lap command freezes the displayed time while the live counter keeps running.
//     When the macro is not defined, lap commands are consumed as no-ops and the
//     display always follows the live time.
//
// Ports
//   clk, rst                      clock; asynchronous active-high reset
//   i_btn_runstop/clear/lap       1-cycle debounced button pulses
//   i_rx_data, i_rx_done          UART byte and its 1-cycle valid strobe
//   i_msec/i_sec/i_min/i_hour     live time from the datapath
//   o_runstop, o_clear            registered levels to the datapath
//   o_state                       00 STOP, 01 RUN, 10 CLEAR
//   o_lap_active                  1 = display frozen at the lap time
//   o_cmd_drop                    1-cycle pulse when a UART command is lost
//   o_disp_msec/sec/min/hour      time presented to the display
module stopwatch_cmd_ctrl #(
  parameter logic [7:0] CMD_RUNSTOP  = 8'h72,
  parameter logic [7:0] CMD_CLEAR    = 8'h63,
  parameter logic [7:0] CMD_LAP      = 8'h6C,
  parameter int         CLEAR_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_runstop,
  input  logic       i_btn_clear,
  input  logic       i_btn_lap,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  input  logic [6:0] i_msec,
  input  logic [5:0] i_sec,
  input  logic [5:0] i_min,
  input  logic [4:0] i_hour,
  output logic       o_runstop,
  output logic       o_clear,
  output logic [1:0] o_state,
  output logic       o_lap_active,
  output logic       o_cmd_drop,
  output logic [6:0] o_disp_msec,
  output logic [5:0] o_disp_sec,
  output logic [5:0] o_disp_min,
  output logic [4:0] o_disp_hour
);

  // State encoding gives o_runstop/o_clear straight from flop bits.
  localparam logic [1:0] ST_STOP  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_CLEAR = 2'b10;

  localparam logic [1:0] C_NONE = 2'd0;
  localparam logic [1:0] C_RS   = 2'd1;
  localparam logic [1:0] C_CLR  = 2'd2;
  localparam logic [1:0] C_LAP  = 2'd3;

  localparam logic [7:0] CLEAR_LOAD = 8'(CLEAR_CYCLES);

  function automatic logic [7:0] to_lower(input logic [7:0] b);
    if (b >= 8'h41 && b <= 8'h5A) return b | 8'h20;
    return b;
  endfunction

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pend_vld_q, pend_vld_d;
  logic [1:0] pend_cmd_q, pend_cmd_d;
  logic       drop_q, drop_d;
  logic [1:0] btn_cmd, uart_cmd, exec_cmd;
  logic [7:0] rx_lc;
  logic       enter_clear;

  // Decode: buttons by fixed priority, UART byte by case-folded match.
  always_comb begin
    btn_cmd = C_NONE;
    if (i_btn_clear)        btn_cmd = C_CLR;
    else if (i_btn_runstop) btn_cmd = C_RS;
    else if (i_btn_lap)     btn_cmd = C_LAP;

    rx_lc    = to_lower(i_rx_data);
    uart_cmd = C_NONE;
    if (i_rx_done) begin
      if (rx_lc == to_lower(CMD_CLEAR))        uart_cmd = C_CLR;
      else if (rx_lc == to_lower(CMD_RUNSTOP)) uart_cmd = C_RS;
      else if (rx_lc == to_lower(CMD_LAP))     uart_cmd = C_LAP;
    end
  end

  // Arbitration: button > pending > new UART. A UART command that cannot run
  // now goes to pending; it is lost only if pending is occupied and stays so.
  always_comb begin
    exec_cmd   = C_NONE;
    pend_vld_d = pend_vld_q;
    pend_cmd_d = pend_cmd_q;
    drop_d     = 1'b0;
    if (btn_cmd != C_NONE) begin
      exec_cmd = btn_cmd;
      if (uart_cmd != C_NONE) begin
        if (!pend_vld_q) begin
          pend_vld_d = 1'b1;
          pend_cmd_d = uart_cmd;
        end else begin
          drop_d = 1'b1;
        end
      end
    end else if (pend_vld_q) begin
      exec_cmd   = pend_cmd_q;
      pend_vld_d = (uart_cmd != C_NONE);
      pend_cmd_d = uart_cmd;
    end else begin
      exec_cmd = uart_cmd;
    end
  end

  // FSM; commands arriving in CLEAR are consumed without effect.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_STOP: begin
        if (exec_cmd == C_RS) begin
          state_d = ST_RUN;
        end else if (exec_cmd == C_CLR) begin
          state_d = ST_CLEAR;
          cnt_d   = CLEAR_LOAD;
        end
      end
      ST_RUN: begin
        if (exec_cmd == C_RS) state_d = ST_STOP;
      end
      ST_CLEAR: begin
        // Counter stops at 1 and never wraps; a load of 0 behaves as 1.
        if (cnt_q <= 8'd1) state_d = ST_STOP;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = ST_STOP;
    endcase
    enter_clear = (state_d == ST_CLEAR) && (state_q != ST_CLEAR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_STOP;
      cnt_q      <= 8'd0;
      pend_vld_q <= 1'b0;
      pend_cmd_q <= C_NONE;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_vld_q <= pend_vld_d;
      pend_cmd_q <= pend_cmd_d;
      drop_q     <= drop_d;
    end
  end

  assign o_state    = state_q;
  assign o_runstop  = state_q[0];
  assign o_clear    = state_q[1];
  assign o_cmd_drop = drop_q;

`ifdef STOPWATCH_LAP_EN
  logic       lap_q, lap_d;
  logic [6:0] lap_msec_q, lap_msec_d;
  logic [5:0] lap_sec_q, lap_sec_d;
  logic [5:0] lap_min_q, lap_min_d;
  logic [4:0] lap_hour_q, lap_hour_d;

  always_comb begin
    lap_d = lap_q;
    if (enter_clear) begin
      lap_d = 1'b0;
    end else if (exec_cmd == C_LAP) begin
      if (state_q == ST_RUN)       lap_d = ~lap_q;
      else if (state_q == ST_STOP) lap_d = 1'b0;
    end
    lap_msec_d = lap_msec_q;
    lap_sec_d  = lap_sec_q;
    lap_min_d  = lap_min_q;
    lap_hour_d = lap_hour_q;
    // Snapshot the live time only on the freeze edge.
    if (lap_d && !lap_q) begin
      lap_msec_d = i_msec;
      lap_sec_d  = i_sec;
      lap_min_d  = i_min;
      lap_hour_d = i_hour;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_q      <= 1'b0;
      lap_msec_q <= '0;
      lap_sec_q  <= '0;
      lap_min_q  <= '0;
      lap_hour_q <= '0;
    end else begin
      lap_q      <= lap_d;
      lap_msec_q <= lap_msec_d;
      lap_sec_q  <= lap_sec_d;
      lap_min_q  <= lap_min_d;
      lap_hour_q <= lap_hour_d;
    end
  end

  assign o_lap_active = lap_q;
  assign o_disp_msec  = lap_q ? lap_msec_q : i_msec;
  assign o_disp_sec   = lap_q ? lap_sec_q  : i_sec;
  assign o_disp_min   = lap_q ? lap_min_q  : i_min;
  assign o_disp_hour  = lap_q ? lap_hour_q : i_hour;
`else
  assign o_lap_active = 1'b0;
  assign o_disp_msec  = i_msec;
  assign o_disp_sec   = i_sec;
  assign o_disp_min   = i_min;
  assign o_disp_hour  = i_hour;
`endif

endmodule
